// File: rtl/mbist_march_ctrl.sv
// March C- MBIST controller: drives a single-port test memory with a 2-cycle
// read path and registered write data, checks every read and logs the first failure.
module mbist_march_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned CAPACITY   = 16,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  mem_write_read,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic [CNT_WIDTH-1:0]  err_count
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(CAPACITY - 1);
  localparam logic [2:0]            ELEM_W0   = 3'd0;
  localparam logic [2:0]            ELEM_R0   = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic                  vld;
    logic [DATA_WIDTH-1:0] exp;
    logic [ADDR_WIDTH-1:0] addr;
    logic [2:0]            elem;
  } chk_t;

  function automatic logic elem_down(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] elem_wval(input logic [2:0] e);
    return ((e == 3'd1) || (e == 3'd3)) ? '1 : '0;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] elem_rexp(input logic [2:0] e);
    return ((e == 3'd2) || (e == 3'd4)) ? '1 : '0;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] elem_first(input logic [2:0] e);
    return elem_down(e) ? ADDR_LAST : '0;
  endfunction

  state_e                state_q, state_d;
  logic [2:0]            elem_q, elem_d;
  logic                  drain_q, drain_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  start_acc_c;
  logic [ADDR_WIDTH-1:0] addr_end_c;

  chk_t                  s1_q, s1_d, s2_q, s2_d;
  logic                  fail_q, fail_d;
  logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
  logic [2:0]            fail_elem_q, fail_elem_d;
  logic [DATA_WIDTH-1:0] fail_data_q, fail_data_d;
  logic [CNT_WIDTH-1:0]  err_q, err_d;
  logic                  mismatch_c;

  // Sequencer: registered memory command describes the cycle named by state_q.
  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    drain_d     = drain_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    start_acc_c = 1'b0;
    addr_end_c  = elem_down(elem_q) ? '0 : ADDR_LAST;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          start_acc_c = 1'b1;
          state_d     = ST_SETUP;
          elem_d      = ELEM_W0;
          addr_d      = elem_first(ELEM_W0);
          wr_d        = 1'b0;
          wdata_d     = elem_wval(ELEM_W0);
        end
      end
      ST_SETUP: begin
        state_d = ST_RUN;
        wr_d    = (elem_q == ELEM_W0);
      end
      ST_RUN: begin
        // Last operation at this address: single-op elements, or the write of r,w.
        if ((elem_q == ELEM_W0) || (elem_q == ELEM_R0) || wr_q) begin
          if (addr_q == addr_end_c) begin
            wr_d = 1'b0;
            if (elem_q == ELEM_R0) begin
              state_d = ST_DRAIN;
              drain_d = 1'b0;
            end else begin
              state_d = ST_SETUP;
              elem_d  = elem_q + 3'd1;
              addr_d  = elem_first(elem_q + 3'd1);
              wdata_d = elem_wval(elem_q + 3'd1);
            end
          end else begin
            addr_d = elem_down(elem_q) ? addr_q - ADDR_WIDTH'(1) : addr_q + ADDR_WIDTH'(1);
            wr_d   = (elem_q == ELEM_W0);
          end
        end else begin
          wr_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        wr_d = 1'b0;
        if (drain_q) state_d = ST_DONE;
        else         drain_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_SETUP) || (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
  end

  // Read-check pipeline aligned to the 2-cycle read latency, plus failure log.
  always_comb begin
    s1_d.vld    = (state_q == ST_RUN) && !wr_q;
    s1_d.exp    = elem_rexp(elem_q);
    s1_d.addr   = addr_q;
    s1_d.elem   = elem_q;
    s2_d        = s1_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    fail_data_d = fail_data_q;
    err_d       = err_q;
    mismatch_c  = s2_q.vld && (mem_rdata != s2_q.exp);
    if (start_acc_c) begin
      fail_d      = 1'b0;
      fail_addr_d = '0;
      fail_elem_d = '0;
      fail_data_d = '0;
      err_d       = '0;
    end else if (mismatch_c) begin
      if (err_q != '1) err_d = err_q + CNT_WIDTH'(1);
      if (!fail_q) begin
        fail_d      = 1'b1;
        fail_addr_d = s2_q.addr;
        fail_elem_d = s2_q.elem;
        fail_data_d = mem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      elem_q      <= '0;
      drain_q     <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      s1_q        <= '0;
      s2_q        <= '0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
      fail_data_q <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      drain_q     <= drain_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
      fail_data_q <= fail_data_d;
      err_q       <= err_d;
    end
  end

  assign mem_write_read = wr_q;
  assign mem_address    = addr_q;
  assign mem_wdata      = wdata_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign fail           = fail_q;
  assign fail_addr      = fail_addr_q;
  assign fail_elem      = fail_elem_q;
  assign fail_data      = fail_data_q;
  assign err_count      = err_q;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Directed bench for mbist_march_ctrl: behavioural memory with selectable faults,
// plus a second instance with a 2-bit error counter fed all-zero read data.
module tb_mbist_march_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       mem_write_read;
  logic [3:0] mem_address;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       busy, done, fail;
  logic [3:0] fail_addr;
  logic [2:0] fail_elem;
  logic [7:0] fail_data;
  logic [15:0] err_count;

  logic       start2;
  logic       wr2;
  logic [3:0] addr2;
  logic [7:0] wdata2;
  logic [7:0] zero_rdata;
  logic       busy2, done2, fail2;
  logic [3:0] fail_addr2;
  logic [2:0] fail_elem2;
  logic [7:0] fail_data2;
  logic [1:0] err2;

  int mode;
  logic preload;
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;
  assign zero_rdata = 8'h00;

  mbist_march_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .CAPACITY(16), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .mem_write_read(mem_write_read), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .done(done), .fail(fail),
    .fail_addr(fail_addr), .fail_elem(fail_elem), .fail_data(fail_data), .err_count(err_count)
  );

  mbist_march_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .CAPACITY(16), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2),
    .mem_write_read(wr2), .mem_address(addr2), .mem_wdata(wdata2),
    .mem_rdata(zero_rdata), .busy(busy2), .done(done2), .fail(fail2),
    .fail_addr(fail_addr2), .fail_elem(fail_elem2), .fail_data(fail_data2), .err_count(err2)
  );

  // Memory: write stores data registered one cycle earlier; read data two cycles later.
  // mode 1: bit 0 stuck-at-1 at addr 9. mode 2: writes to addr 5 lost, bit 5 reads 0 there.
  logic [7:0] mem [16];
  logic [7:0] wd_q, rd1_q;

  function automatic logic [7:0] rd_val(input logic [3:0] a);
    logic [7:0] v;
    v = mem[a];
    if (mode == 1 && a == 4'd9) v = v | 8'h01;
    if (mode == 2 && a == 4'd5) v = v & 8'hDF;
    return v;
  endfunction

  always @(posedge clk) begin
    wd_q <= mem_wdata;
    if (preload) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'hFF;
    end else if (mem_write_read && !(mode == 2 && mem_address == 4'd5)) begin
      mem[mem_address] <= wd_q;
    end
    rd1_q     <= rd_val(mem_address);
    mem_rdata <= rd1_q;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Start a test, count busy cycles until done; optionally pulse start or rst mid-run.
  task automatic run_test(input int rst_at, input int start_at,
                          output int cycles, output int fail_at, output logic [2:0] first_flags);
    bit fin;
    cycles = 0; fail_at = -1; fin = 0; first_flags = 3'b111;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 1000 && !fin; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 0) first_flags = {done, fail, (err_count != 0)};
      if (done) begin
        fin = 1;
      end else if (busy) begin
        if (fail && fail_at < 0) fail_at = cycles;
        if (cycles == start_at) start = 1'b1;
        if (cycles == rst_at) begin
          rst = 1'b1;
          @(negedge clk);
          check("rst_flags", {29'd0, busy, done, fail}, 32'd0);
          check("rst_err", {16'd0, err_count}, 32'd0);
          check("rst_fail_info", {17'd0, fail_addr, fail_elem, fail_data}, 32'd0);
          check("rst_mem", {19'd0, mem_write_read, mem_address, mem_wdata}, 32'd0);
          rst = 1'b0;
          fin = 1;
        end
        cycles++;
      end
    end
    if (!fin) check("timeout", 32'd0, 32'd1);
  endtask

  int cyc, fat;
  logic [2:0] ff;

  initial begin
    rst = 1'b1; start = 1'b0; start2 = 1'b0; mode = 0; preload = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_flags", {29'd0, busy, done, fail}, 32'd0);
    check("reset_err", {16'd0, err_count}, 32'd0);
    check("reset_mem", {19'd0, mem_write_read, mem_address, mem_wdata}, 32'd0);
    rst = 1'b0;

    // Ideal memory, with an ignored start pulse mid-test.
    run_test(-1, 50, cyc, fat, ff);
    check("ideal_cycles", cyc, 168);
    check("ideal_done", {31'd0, done}, 32'd1);
    check("ideal_fail", {31'd0, fail}, 32'd0);
    check("ideal_err", {16'd0, err_count}, 32'd0);

    // Bit 0 stuck-at-1 at addr 9: r0 reads in E1, E3, E5 fail.
    mode = 1;
    run_test(-1, -1, cyc, fat, ff);
    check("sa1_cycles", cyc, 168);
    check("sa1_fail_latency", fat, 39);
    check("sa1_fail", {31'd0, fail}, 32'd1);
    check("sa1_elem", {29'd0, fail_elem}, 32'd1);
    check("sa1_addr", {28'd0, fail_addr}, 32'd9);
    check("sa1_data", {24'd0, fail_data}, 32'h01);
    check("sa1_err", {16'd0, err_count}, 32'd3);

    // Restart from DONE clears the log and reruns clean.
    mode = 0;
    run_test(-1, -1, cyc, fat, ff);
    check("restart_cleared", {29'd0, ff}, 32'd0);
    check("restart_cycles", cyc, 168);
    check("restart_fail", {31'd0, fail}, 32'd0);
    check("restart_err", {16'd0, err_count}, 32'd0);

    // Reset in the middle of E3 after a failure was logged, then a clean rerun.
    mode = 1;
    run_test(90, -1, cyc, fat, ff);
    mode = 0;
    run_test(-1, -1, cyc, fat, ff);
    check("post_rst_cycles", cyc, 168);
    check("post_rst_fail", {31'd0, fail}, 32'd0);

    // Lost writes at addr 5 with 0xFF preload and bit 5 reading 0: every read there fails.
    @(posedge clk); #1 preload = 1'b1;
    @(posedge clk); #1 preload = 1'b0;
    mode = 2;
    run_test(-1, -1, cyc, fat, ff);
    check("wa_fail_latency", fat, 31);
    check("wa_elem", {29'd0, fail_elem}, 32'd1);
    check("wa_addr", {28'd0, fail_addr}, 32'd5);
    check("wa_data", {24'd0, fail_data}, 32'hDF);
    check("wa_err", {16'd0, err_count}, 32'd5);

    // All-zero read data with a 2-bit counter: saturation and first fail at E2 addr 0.
    @(posedge clk); #1 start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    cyc = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (done2) break;
      if (busy2) cyc++;
    end
    check("sat_done", {31'd0, done2}, 32'd1);
    check("sat_cycles", cyc, 168);
    check("sat_err", {30'd0, err2}, 32'd3);
    check("sat_elem", {29'd0, fail_elem2}, 32'd2);
    check("sat_addr", {28'd0, fail_addr2}, 32'd0);
    check("sat_data", {24'd0, fail_data2}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
